wb_mem_responder: RTL and testbench
===================================

# wb_mem_responder

Synthesizable Wishbone classic-cycle slave: the responder end of the wishbone_interface that our benches drive as master. It backs a byte-enabled word memory and answers single and back-to-back transfers with programmable read/write wait states. It flags out-of-range addresses and abandoned cycles. It stands in for the SDRAM controller when isolating master-side sequences, and serves as a scratch memory on the system bus.

## Interface
- AW, 8: word-address bits; depth = 2**AW words
- RD_WAIT, 2: extra cycles before a read ack (0..15)
- WR_WAIT, 1: extra cycles before a write ack (0..15)
- CNT_W, 16: width of the statistics counters
- sys_clk  in  1  system clock; all logic on rising edge
- RESETN  in  1  asynchronous, active-low reset
- wb_cyc_i  in  1  bus cycle valid
- wb_stb_i  in  1  strobe; request when wb_cyc_i & wb_stb_i
- wb_we_i  in  1  1 = write, 0 = read
- wb_addr_i  in  32  word address (byte address >> 2)
- wb_sel_i  in  4  byte-lane enables; write only
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data; valid while wb_ack_o = 1
- wb_ack_o  out  1  transfer complete, one-cycle pulse
- wb_err_o  out  1  transfer error, one-cycle pulse
- wr_cnt  out  CNT_W  completed writes
- rd_cnt  out  CNT_W  completed reads
- abort_cnt  out  CNT_W  cycles dropped before ack

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - On cyc & stb, latch addr, we, sel and dat_i.
  - Load the wait counter with WR_WAIT or RD_WAIT.
  - Go to WAIT if the loaded value is nonzero, otherwise to RESP.
- WAIT:
  - Counter decrements every cycle; at 1 the next state is RESP.
  - If cyc or stb drops, return to IDLE. No memory access, no ack, abort_cnt += 1.
- Range check: wb_addr_i[31:AW] != 0 means error.
- Entry to RESP, in range:
  - Write: commit the latched bytes where sel = 1. Bytes where sel = 0 are untouched. sel = 0000 still acks and still counts.
  - Read: load wb_dat_o from mem[addr[AW-1:0]]. sel is ignored.
- Entry to RESP, out of range: no memory access, wb_dat_o unchanged, counters unchanged.
- RESP:
  - wb_ack_o (or wb_err_o) is high for exactly this cycle; the next state is always IDLE.
  - wr_cnt or rd_cnt increments on the RESP cycle of an in-range transfer.
  - ack and err are never high together.
- wb_dat_o holds its last read value outside RESP.
- Input changes after the latch cycle are ignored. Data and address come only from the latched copy.
- Counters wrap from all-ones to 0.
- Reset:
  - All outputs go to 0 and the FSM to IDLE. This holds mid-WAIT or mid-RESP too.
  - A transfer in flight is discarded with no write.
  - Memory contents are not reset (X after power-up) and are retained across RESETN.

## Timing
- Request first sampled at edge N. ack/err is high in cycle N+1+WAIT, with WAIT = RD_WAIT or WR_WAIT.
- Zero-wait read: ack on the edge after the request. Data is registered, so there is no combinational path from address to dat_o.
- The FSM is in IDLE the cycle after RESP. A request held or reasserted there is accepted, so back-to-back throughput is one transfer per 2+WAIT cycles.
- A read issued the cycle after a write RESP to the same address returns the new data.
- Abort detection is sampled at each WAIT edge. A drop coinciding with the final WAIT edge still aborts, and RESP is not entered.

## Structure
- Package wb_resp_pkg holds:
  - state enum { IDLE, WAIT, RESP }
  - WB_AW = 32, WB_DW = 32, WB_SELW = 4
  - wait-counter width (4 bits)
- Sub-module wb_resp_ram:
  - single-port, AW x 32, byte-write-enable, synchronous read, no reset
  - instantiated once
- The FSM, latch registers, range check and counters live in the top.

## Test plan
- Reset then idle: RESETN low for 10 cycles, release. wb_ack_o = wb_err_o = 0, wb_dat_o = 0, all counters 0.
- Single write/read, defaults: write 0x12345678 to word 0x10, sel = 1111. ack on cycle 3 (1+WR_WAIT+1). Read 0x10 acks on cycle 4 with 0x12345678; wr_cnt = rd_cnt = 1.
- Byte lanes: write 0xFFFFFFFF, then 0x00000000 with sel = 0101, to word 0x20. Read returns 0xFF00FF00.
- Burst of 8 back-to-back writes to words 0..7, then 8 reads, data from a $random queue as the master bench drives it. Every read matches, each ack is a single-cycle pulse, wr_cnt = rd_cnt = 8.
- Out of range with AW = 8: read word 0x100. wb_err_o pulses on cycle 4 and wb_ack_o stays 0. wb_dat_o keeps its prior value; rd_cnt is unchanged.
- Abort and reset:
  - Drop stb one cycle into a RD_WAIT = 2 read: no ack, abort_cnt = 1.
  - Assert RESETN low during the WAIT of a write to 0x30 holding 0xAAAA5555: outputs go 0 immediately. A later read of 0x30 returns the pre-write value.

Source files
------------

// File: rtl/wb_resp_pkg.sv
// Purpose: shared constants and FSM state type for the Wishbone memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: bus widths, wait-counter width, responder state enum.
package wb_resp_pkg;

  localparam int WB_AW   = 32;  // Wishbone word-address width
  localparam int WB_DW   = 32;  // Wishbone data width
  localparam int WB_SELW = 4;   // byte-lane enables per word
  localparam int WAIT_CW = 4;   // wait-state counter width (0..15)

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_resp_ram.sv
// Purpose: single-port byte-write-enable word memory behind the responder.
// Latency: write commits on the clock edge; read data registered one edge after re.
// Backpressure: none; one access per cycle, caller never asserts we and re together.
// Ports: sys_clk; we/be/wdat write side; re read enable; addr word index; rdat registered read data.
// rdat only changes when re is high, so it holds the last read word. No reset: contents persist.
module wb_resp_ram
  import wb_resp_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic               sys_clk,
  input  logic               we,
  input  logic               re,
  input  logic [AW-1:0]      addr,
  input  logic [WB_SELW-1:0] be,
  input  logic [WB_DW-1:0]   wdat,
  output logic [WB_DW-1:0]   rdat
);

  logic [WB_DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge sys_clk) begin
    if (we) begin
      for (int b = 0; b < WB_SELW; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdat[8*b +: 8];
      end
    end
    if (re) rdat <= mem[addr];
  end

endmodule

// File: rtl/wb_mem_responder.sv
// Purpose: Wishbone classic-cycle slave backed by a byte-enabled word RAM, with wait states and stats.
// Latency: ack/err in cycle N+1+WAIT after the request is first sampled at edge N (WAIT = RD_WAIT/WR_WAIT).
// Backpressure: ack withheld during wait states; master dropping cyc/stb in WAIT aborts the transfer.
// Ports: sys_clk, RESETN (async, active-low); wb_cyc_i/stb_i/we_i/addr_i/sel_i/dat_i request;
//        wb_dat_o/ack_o/err_o response; wr_cnt/rd_cnt/abort_cnt wrapping statistics counters.
module wb_mem_responder
  import wb_resp_pkg::*;
#(
  parameter int AW      = 8,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 1,
  parameter int CNT_W   = 16
) (
  input  logic               sys_clk,
  input  logic               RESETN,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [WB_AW-1:0]   wb_addr_i,
  input  logic [WB_SELW-1:0] wb_sel_i,
  input  logic [WB_DW-1:0]   wb_dat_i,
  output logic [WB_DW-1:0]   wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic [CNT_W-1:0]   wr_cnt,
  output logic [CNT_W-1:0]   rd_cnt,
  output logic [CNT_W-1:0]   abort_cnt
);

  localparam logic [WAIT_CW-1:0] RD_LD = WAIT_CW'(RD_WAIT);
  localparam logic [WAIT_CW-1:0] WR_LD = WAIT_CW'(WR_WAIT);

  wb_state_t          state_q;
  logic [WAIT_CW-1:0] wcnt_q;
  logic               we_q;
  logic [WB_SELW-1:0] sel_q;
  logic [WB_DW-1:0]   dat_q;
  logic [WB_AW-1:0]   addr_q;
  logic               oor_q;      // current RESP is an error response
  logic               dat_vld_q;  // RAM read register holds a real read since reset
  logic [WB_DW-1:0]   ram_rdat;

  logic               req, in_idle, in_wait, enter_resp;
  logic [WAIT_CW-1:0] wait_ld;
  logic               acc_we, acc_oor;
  logic [WB_SELW-1:0] acc_sel;
  logic [WB_DW-1:0]   acc_dat;
  logic [WB_AW-1:0]   acc_addr;

  assign req     = wb_cyc_i & wb_stb_i;
  assign in_idle = (state_q == S_IDLE);
  assign in_wait = (state_q == S_WAIT);
  assign wait_ld = wb_we_i ? WR_LD : RD_LD;

  // The memory access happens on the edge that enters RESP. With zero wait
  // states that is the latch edge itself, so the bus is used directly; the
  // value is identical to what is being latched. Otherwise the latched copy.
  assign enter_resp = in_idle ? (req & (wait_ld == '0))
                              : (in_wait & req & (wcnt_q == WAIT_CW'(1)));
  assign acc_we   = in_idle ? wb_we_i   : we_q;
  assign acc_sel  = in_idle ? wb_sel_i  : sel_q;
  assign acc_dat  = in_idle ? wb_dat_i  : dat_q;
  assign acc_addr = in_idle ? wb_addr_i : addr_q;
  assign acc_oor  = (acc_addr >> AW) != '0;

  wb_resp_ram #(.AW(AW)) u_ram (
    .sys_clk (sys_clk),
    .we      (enter_resp & ~acc_oor & acc_we),
    .re      (enter_resp & ~acc_oor & ~acc_we),
    .addr    (acc_addr[AW-1:0]),
    .be      (acc_sel),
    .wdat    (acc_dat),
    .rdat    (ram_rdat)
  );

  // RAM output is registered and only updated by in-range reads, so it already
  // holds the last read value; the valid flag gives the reset value of 0.
  assign wb_dat_o = dat_vld_q ? ram_rdat : '0;
  assign wb_ack_o = (state_q == S_RESP) & ~oor_q;
  assign wb_err_o = (state_q == S_RESP) &  oor_q;

  always_ff @(posedge sys_clk or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= S_IDLE;
      wcnt_q    <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      dat_q     <= '0;
      addr_q    <= '0;
      oor_q     <= 1'b0;
      dat_vld_q <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      abort_cnt <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            we_q    <= wb_we_i;
            sel_q   <= wb_sel_i;
            dat_q   <= wb_dat_i;
            addr_q  <= wb_addr_i;
            wcnt_q  <= wait_ld;
            state_q <= (wait_ld == '0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          // A drop is checked before the countdown, so a drop on the last
          // wait edge still aborts instead of responding.
          if (!req) begin
            state_q   <= S_IDLE;
            abort_cnt <= abort_cnt + CNT_W'(1);
          end else begin
            wcnt_q <= wcnt_q - WAIT_CW'(1);
            if (wcnt_q == WAIT_CW'(1)) state_q <= S_RESP;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (enter_resp) begin
        oor_q <= acc_oor;
        if (!acc_oor) begin
          if (acc_we) begin
            wr_cnt <= wr_cnt + CNT_W'(1);
          end else begin
            rd_cnt    <= rd_cnt + CNT_W'(1);
            dat_vld_q <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_mem_responder.sv
// Purpose: self-checking bench for wb_mem_responder using a memory model and expected-read queue.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_wb_mem_responder;

  localparam int AW      = 8;
  localparam int RD_WAIT = 2;
  localparam int WR_WAIT = 1;
  localparam int CNT_W   = 16;

  logic             sys_clk = 1'b0;
  logic             RESETN  = 1'b0;
  logic             wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [31:0]      wb_addr_i = '0;
  logic [3:0]       wb_sel_i  = '0;
  logic [31:0]      wb_dat_i  = '0;
  logic [31:0]      wb_dat_o;
  logic             wb_ack_o, wb_err_o;
  logic [CNT_W-1:0] wr_cnt, rd_cnt, abort_cnt;

  always #5 sys_clk = ~sys_clk;

  wb_mem_responder #(.AW(AW), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT), .CNT_W(CNT_W)) dut (
    .sys_clk   (sys_clk),
    .RESETN    (RESETN),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_we_i   (wb_we_i),
    .wb_addr_i (wb_addr_i),
    .wb_sel_i  (wb_sel_i),
    .wb_dat_i  (wb_dat_i),
    .wb_dat_o  (wb_dat_o),
    .wb_ack_o  (wb_ack_o),
    .wb_err_o  (wb_err_o),
    .wr_cnt    (wr_cnt),
    .rd_cnt    (rd_cnt),
    .abort_cnt (abort_cnt)
  );

  int checks = 0, failures = 0;
  int exp_wr = 0, exp_rd = 0, exp_ab = 0;
  logic [31:0] model [0:255];
  logic [31:0] exp_q [$];

  function automatic void model_write(input int a, input logic [3:0] s, input logic [31:0] d);
    for (int b = 0; b < 4; b++)
      if (s[b]) model[a][8*b +: 8] = d[8*b +: 8];
  endfunction

  // One transfer; inputs are scrambled after the latch edge, which the DUT must ignore.
  task automatic do_xfer(input logic we, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, output int lat, output logic got_ack,
                         output logic got_err, output logic [31:0] rd);
    @(posedge sys_clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_addr_i = a; wb_sel_i = s; wb_dat_i = d;
    lat = -1; got_ack = 1'b0; got_err = 1'b0; rd = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge sys_clk);
      if (wb_ack_o || wb_err_o) begin
        lat = c; got_ack = wb_ack_o; got_err = wb_err_o; rd = wb_dat_o;
        break;
      end
      if (c == 2) begin
        wb_we_i = ~we; wb_addr_i = ~a; wb_sel_i = ~s; wb_dat_i = ~d;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  // Starts a transfer, drops cyc/stb after hold_edges more rising edges, watches for any response.
  task automatic start_and_drop(input logic we, input logic [31:0] a, input logic [31:0] d,
                                input int hold_edges, output logic seen);
    @(posedge sys_clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_addr_i = a; wb_sel_i = 4'hF; wb_dat_i = d;
    repeat (hold_edges) @(posedge sys_clk);
    #1 wb_stb_i = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge sys_clk);
      if (wb_ack_o || wb_err_o) seen = 1'b1;
    end
    wb_cyc_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic test_reset();
    RESETN = 1'b0;
    repeat (10) @(posedge sys_clk);
    #1 RESETN = 1'b1;
    @(negedge sys_clk);
    checks++; if (wb_ack_o !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b want=0", wb_ack_o); end
    checks++; if (wb_err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", wb_err_o); end
    checks++; if (wb_dat_o !== 32'h0) begin failures++; $display("FAIL reset_dat got=%h want=0", wb_dat_o); end
    checks++; if (wr_cnt !== '0 || rd_cnt !== '0 || abort_cnt !== '0) begin
      failures++; $display("FAIL reset_cnt got wr=%0d rd=%0d ab=%0d want 0/0/0", wr_cnt, rd_cnt, abort_cnt);
    end
  endtask

  task automatic test_single();
    int lat; logic a, e; logic [31:0] rd, exp;
    do_xfer(1'b1, 32'h10, 4'hF, 32'h12345678, lat, a, e, rd);
    model_write(8'h10, 4'hF, 32'h12345678); exp_wr++;
    checks++; if (a !== 1'b1 || e !== 1'b0) begin failures++; $display("FAIL single_wr_ack got ack=%b err=%b want 1/0", a, e); end
    checks++; if (lat != WR_WAIT + 2) begin failures++; $display("FAIL single_wr_lat got=%0d want=%0d", lat, WR_WAIT + 2); end
    exp_q.push_back(model[8'h10]); exp_rd++;
    do_xfer(1'b0, 32'h10, 4'h0, 32'h0, lat, a, e, rd);
    checks++; if (a !== 1'b1 || e !== 1'b0) begin failures++; $display("FAIL single_rd_ack got ack=%b err=%b want 1/0", a, e); end
    checks++; if (lat != RD_WAIT + 2) begin failures++; $display("FAIL single_rd_lat got=%0d want=%0d", lat, RD_WAIT + 2); end
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin failures++; $display("FAIL single_rd_dat got=%h want=%h", rd, exp); end
    checks++; if (wr_cnt !== CNT_W'(exp_wr) || rd_cnt !== CNT_W'(exp_rd)) begin
      failures++; $display("FAIL single_cnt got wr=%0d rd=%0d want %0d/%0d", wr_cnt, rd_cnt, exp_wr, exp_rd);
    end
  endtask

  task automatic test_byte_lanes();
    int lat; logic a, e; logic [31:0] rd, exp;
    do_xfer(1'b1, 32'h20, 4'hF, 32'hFFFFFFFF, lat, a, e, rd);
    model_write(8'h20, 4'hF, 32'hFFFFFFFF); exp_wr++;
    do_xfer(1'b1, 32'h20, 4'b0101, 32'h00000000, lat, a, e, rd);
    model_write(8'h20, 4'b0101, 32'h00000000); exp_wr++;
    // sel = 0000 must still ack and count but leave the word untouched
    do_xfer(1'b1, 32'h20, 4'b0000, 32'h12341234, lat, a, e, rd);
    exp_wr++;
    checks++; if (a !== 1'b1 || e !== 1'b0) begin failures++; $display("FAIL sel0_ack got ack=%b err=%b want 1/0", a, e); end
    checks++; if (wr_cnt !== CNT_W'(exp_wr)) begin failures++; $display("FAIL sel0_cnt got=%0d want=%0d", wr_cnt, exp_wr); end
    exp_q.push_back(model[8'h20]); exp_rd++;
    do_xfer(1'b0, 32'h20, 4'hF, 32'h0, lat, a, e, rd);
    exp = exp_q.pop_front();
    checks++; if (rd !== exp || exp !== 32'hFF00FF00) begin failures++; $display("FAIL byte_lanes got=%h want=%h", rd, 32'hFF00FF00); end
  endtask

  task automatic stream(input logic w, input int n);
    int t, exp_t; logic got; logic [31:0] d, exp;
    @(posedge sys_clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = w; wb_sel_i = 4'hF;
    for (int i = 0; i < n; i++) begin
      wb_addr_i = 32'(i);
      if (w) begin
        d = $urandom; wb_dat_i = d; model[i] = d; exp_wr++;
      end else begin
        exp_q.push_back(model[i]); exp_rd++;
      end
      exp_t = (i == 0 ? 2 : 1) + (w ? WR_WAIT : RD_WAIT);
      t = 0; got = 1'b0;
      while (!got && t < 40) begin
        @(negedge sys_clk); t++;
        got = wb_ack_o | wb_err_o;
      end
      checks++;
      if (!got || wb_ack_o !== 1'b1 || wb_err_o !== 1'b0) begin
        failures++; $display("FAIL b2b_ack item=%0d got ack=%b err=%b want 1/0", i, wb_ack_o, wb_err_o);
        break;
      end
      checks++; if (t != exp_t) begin failures++; $display("FAIL b2b_spacing item=%0d got=%0d want=%0d", i, t, exp_t); end
      if (!w) begin
        exp = exp_q.pop_front();
        checks++; if (wb_dat_o !== exp) begin failures++; $display("FAIL b2b_rd_dat item=%0d got=%h want=%h", i, wb_dat_o, exp); end
      end
      if (i == n - 1) begin wb_cyc_i = 1'b0; wb_stb_i = 1'b0; end
      @(negedge sys_clk);
      checks++; if (wb_ack_o !== 1'b0) begin failures++; $display("FAIL b2b_pulse item=%0d ack still %b want 0", i, wb_ack_o); end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    stream(1'b1, 8);
    stream(1'b0, 8);
    checks++; if (wr_cnt !== CNT_W'(exp_wr) || rd_cnt !== CNT_W'(exp_rd)) begin
      failures++; $display("FAIL b2b_cnt got wr=%0d rd=%0d want %0d/%0d", wr_cnt, rd_cnt, exp_wr, exp_rd);
    end
  endtask

  task automatic test_out_of_range();
    int lat; logic a, e; logic [31:0] rd, exp, prev;
    prev = wb_dat_o;
    do_xfer(1'b0, 32'h100, 4'hF, 32'h0, lat, a, e, rd);
    checks++; if (e !== 1'b1 || a !== 1'b0) begin failures++; $display("FAIL oor_rd_resp got ack=%b err=%b want 0/1", a, e); end
    checks++; if (lat != RD_WAIT + 2) begin failures++; $display("FAIL oor_rd_lat got=%0d want=%0d", lat, RD_WAIT + 2); end
    checks++; if (rd !== prev) begin failures++; $display("FAIL oor_rd_dat got=%h want=%h", rd, prev); end
    checks++; if (rd_cnt !== CNT_W'(exp_rd)) begin failures++; $display("FAIL oor_rd_cnt got=%0d want=%0d", rd_cnt, exp_rd); end
    // Out-of-range write must not alias onto word 0x10
    do_xfer(1'b1, 32'h110, 4'hF, 32'hDEADBEEF, lat, a, e, rd);
    checks++; if (e !== 1'b1 || a !== 1'b0 || wr_cnt !== CNT_W'(exp_wr)) begin
      failures++; $display("FAIL oor_wr got ack=%b err=%b wr=%0d want 0/1/%0d", a, e, wr_cnt, exp_wr);
    end
    exp_q.push_back(model[8'h10]); exp_rd++;
    do_xfer(1'b0, 32'h10, 4'hF, 32'h0, lat, a, e, rd);
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin failures++; $display("FAIL oor_alias got=%h want=%h", rd, exp); end
    // Highest in-range word
    do_xfer(1'b1, 32'hFF, 4'hF, 32'hC0FFEE11, lat, a, e, rd);
    model_write(8'hFF, 4'hF, 32'hC0FFEE11); exp_wr++;
    exp_q.push_back(model[8'hFF]); exp_rd++;
    do_xfer(1'b0, 32'hFF, 4'hF, 32'h0, lat, a, e, rd);
    exp = exp_q.pop_front();
    checks++; if (a !== 1'b1 || rd !== exp) begin failures++; $display("FAIL top_word got ack=%b dat=%h want 1/%h", a, rd, exp); end
  endtask

  task automatic test_abort();
    int lat; logic a, e, seen; logic [31:0] rd, exp;
    // Drop one cycle into a read's wait
    start_and_drop(1'b0, 32'h10, 32'h0, 1, seen); exp_ab++;
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_rd_resp got response=%b want 0", seen); end
    checks++; if (abort_cnt !== CNT_W'(exp_ab) || rd_cnt !== CNT_W'(exp_rd)) begin
      failures++; $display("FAIL abort_rd_cnt got ab=%0d rd=%0d want %0d/%0d", abort_cnt, rd_cnt, exp_ab, exp_rd);
    end
    // Drop on the final wait edge of a read
    start_and_drop(1'b0, 32'h10, 32'h0, 2, seen); exp_ab++;
    checks++; if (seen !== 1'b0 || abort_cnt !== CNT_W'(exp_ab)) begin
      failures++; $display("FAIL abort_rd_last got response=%b ab=%0d want 0/%0d", seen, abort_cnt, exp_ab);
    end
    // Aborted write on its final wait edge leaves memory untouched
    do_xfer(1'b1, 32'h40, 4'hF, 32'h01020304, lat, a, e, rd);
    model_write(8'h40, 4'hF, 32'h01020304); exp_wr++;
    start_and_drop(1'b1, 32'h40, 32'h55AA55AA, 1, seen); exp_ab++;
    checks++; if (seen !== 1'b0 || abort_cnt !== CNT_W'(exp_ab) || wr_cnt !== CNT_W'(exp_wr)) begin
      failures++; $display("FAIL abort_wr got response=%b ab=%0d wr=%0d want 0/%0d/%0d", seen, abort_cnt, wr_cnt, exp_ab, exp_wr);
    end
    exp_q.push_back(model[8'h40]); exp_rd++;
    do_xfer(1'b0, 32'h40, 4'hF, 32'h0, lat, a, e, rd);
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin failures++; $display("FAIL abort_wr_mem got=%h want=%h", rd, exp); end
  endtask

  task automatic test_reset_mid();
    int lat; logic a, e; logic [31:0] rd, exp;
    do_xfer(1'b1, 32'h30, 4'hF, 32'h0BADF00D, lat, a, e, rd);
    model_write(8'h30, 4'hF, 32'h0BADF00D); exp_wr++;
    exp_q.push_back(model[8'h30]); exp_rd++;
    do_xfer(1'b0, 32'h30, 4'hF, 32'h0, lat, a, e, rd);
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin failures++; $display("FAIL rst_pre_rd got=%h want=%h", rd, exp); end
    // Write in flight, reset lands during its wait state
    @(posedge sys_clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_addr_i = 32'h30; wb_sel_i = 4'hF; wb_dat_i = 32'hAAAA5555;
    @(posedge sys_clk); #1 RESETN = 1'b0;
    #1;
    exp_wr = 0; exp_rd = 0; exp_ab = 0;
    checks++; if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0 || wb_dat_o !== 32'h0) begin
      failures++; $display("FAIL rst_mid_out got ack=%b err=%b dat=%h want 0/0/0", wb_ack_o, wb_err_o, wb_dat_o);
    end
    checks++; if (wr_cnt !== '0 || rd_cnt !== '0 || abort_cnt !== '0) begin
      failures++; $display("FAIL rst_mid_cnt got wr=%0d rd=%0d ab=%0d want 0/0/0", wr_cnt, rd_cnt, abort_cnt);
    end
    repeat (3) @(posedge sys_clk);
    #1 wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge sys_clk); #1 RESETN = 1'b1;
    exp_q.push_back(model[8'h30]); exp_rd++;
    do_xfer(1'b0, 32'h30, 4'hF, 32'h0, lat, a, e, rd);
    exp = exp_q.pop_front();
    checks++; if (a !== 1'b1 || rd !== exp) begin failures++; $display("FAIL rst_mem_kept got ack=%b dat=%h want 1/%h", a, rd, exp); end
    checks++; if (wr_cnt !== CNT_W'(exp_wr) || rd_cnt !== CNT_W'(exp_rd)) begin
      failures++; $display("FAIL rst_post_cnt got wr=%0d rd=%0d want %0d/%0d", wr_cnt, rd_cnt, exp_wr, exp_rd);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_byte_lanes();
    test_back_to_back();
    test_out_of_range();
    test_abort();
    test_reset_mid();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
